// File: rtl/bram_output_streamer_if.sv
// rtl/bram_output_streamer_if.sv - AXI-Stream-like master/slave bundle for the BRAM readout stream.
interface bram_output_streamer_if #(
   parameter int DW = 16
) ();
   logic [DW-1:0] tdata;
   logic          tvalid;
   logic          tready;
   logic          tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/bram_output_streamer.sv
// rtl/bram_output_streamer.sv - reads a row range from all output BRAM banks and serializes it onto a stream.
module bram_output_streamer #(
   parameter int DW         = 16,
   parameter int NUM_BRAMS  = 16,
   parameter int ADDR_WIDTH = 9,
   parameter int DEPTH      = 512
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start,
   input  logic [ADDR_WIDTH-1:0]            base_addr,
   input  logic [ADDR_WIDTH:0]              num_words,
   output logic                             ext_read_mode,
   output logic [NUM_BRAMS*ADDR_WIDTH-1:0]  ext_read_addr_flat,
   input  logic [NUM_BRAMS*DW-1:0]          bram_read_data_flat,
   bram_output_streamer_if.master           m_axis,
   output logic                             busy,
   output logic                             done
);
   localparam int                    COL_W     = (NUM_BRAMS > 1) ? $clog2(NUM_BRAMS) : 1;
   localparam logic [COL_W-1:0]      COL_LAST  = COL_W'(NUM_BRAMS - 1);
   localparam logic [COL_W-1:0]      COL_ONE   = COL_W'(1);
   localparam logic [ADDR_WIDTH:0]   ROWS_MAX  = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   ROWS_ONE  = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_CAPTURE,
      S_STREAM,
      S_DONE
   } state_t;

   state_t                    state_q, state_d;
   logic [ADDR_WIDTH-1:0]     rd_addr_q, rd_addr_d;
   logic [ADDR_WIDTH:0]       rows_left_q, rows_left_d;
   logic [COL_W-1:0]          col_q, col_d;
   logic [NUM_BRAMS*DW-1:0]   row_buf_q, row_buf_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         rd_addr_q   <= '0;
         rows_left_q <= '0;
         col_q       <= '0;
         row_buf_q   <= '0;
      end else begin
         state_q     <= state_d;
         rd_addr_q   <= rd_addr_d;
         rows_left_q <= rows_left_d;
         col_q       <= col_d;
         row_buf_q   <= row_buf_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      rd_addr_d   = rd_addr_q;
      rows_left_d = rows_left_q;
      col_d       = col_q;
      row_buf_d   = row_buf_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (num_words == '0) begin
                  state_d = S_DONE;
               end else begin
                  rd_addr_d   = base_addr;
                  rows_left_d = (num_words > ROWS_MAX) ? ROWS_MAX : num_words;
                  state_d     = S_ADDR;
               end
            end
         end
         S_ADDR: begin
            state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            // BRAM has one cycle of read latency, so the row addressed in ADDR is on the bus now.
            row_buf_d = bram_read_data_flat;
            col_d     = '0;
            state_d   = S_STREAM;
         end
         S_STREAM: begin
            if (m_axis.tready) begin
               if (col_q == COL_LAST) begin
                  col_d       = '0;
                  rows_left_d = rows_left_q - ROWS_ONE;
                  rd_addr_d   = (rd_addr_q == ADDR_LAST) ? '0 : rd_addr_q + ADDR_ONE;
                  state_d     = (rows_left_q == ROWS_ONE) ? S_DONE : S_ADDR;
               end else begin
                  col_d = col_q + COL_ONE;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Every output is decoded from registered state; tready only reaches outputs via the next state.
   assign ext_read_mode      = (state_q == S_ADDR) || (state_q == S_CAPTURE) || (state_q == S_STREAM);
   assign ext_read_addr_flat = {NUM_BRAMS{rd_addr_q}};
   assign busy               = (state_q != S_IDLE);
   assign done               = (state_q == S_DONE);
   assign m_axis.tvalid      = (state_q == S_STREAM);
   assign m_axis.tdata       = row_buf_q[col_q*DW +: DW];
   assign m_axis.tlast       = (state_q == S_STREAM) && (col_q == COL_LAST) && (rows_left_q == ROWS_ONE);

endmodule
